regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the single-cycle RISC-V core. It replaces the fixed 32×32, two-read-port register file. It adds configurable width, depth and read-port count, plus optional write-to-read bypass. Register state is exported through a handshaked, cycle-accurate dump engine rather than simulation-only file dumps. It sits between decode (read addresses) and writeback (write port); the dump port feeds the debug/trace unit.

## Interface
Parameters:
- XLEN, 32, register data width in bits (≥8)
- DEPTH, 32, number of registers (power of two, ≥4); register 0 is hardwired zero
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NRD, 2, number of combinational read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to read ports; 0 = reads return stored value

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- rd_addr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- wr_en_i  in  1  write enable
- wr_addr_i  in  AW  write address
- wr_data_i  in  XLEN  write data
- dump_start_i  in  1  request a full register dump (sampled in IDLE only)
- dump_busy_o  out  1  dump engine not IDLE
- dump_valid_o  out  1  dump beat valid
- dump_ready_i  in  1  consumer accepts beat
- dump_addr_o  out  AW  register index of current beat
- dump_data_o  out  XLEN  register value of current beat
- dump_done_o  out  1  one-cycle pulse after final beat accepted

## Operation
- Storage: DEPTH×XLEN flops; reset clears all to 0.
- Write: on posedge with wr_en_i=1 and wr_addr_i≠0, mem[wr_addr_i]←wr_data_i. Writes to address 0 are dropped; mem[0] stays 0.
- Read port k, combinational, in priority order:
  - rd_addr=0 → 0.
  - BYPASS=1, wr_en_i=1 and wr_addr_i=rd_addr → wr_data_i.
  - Otherwise mem[rd_addr].
- All NRD ports are independent; identical addresses return identical data.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start_i=1 → SEND, idx←0, load beat.
  - SEND: dump_valid_o=1. On dump_valid_o&&dump_ready_i: if idx=DEPTH-1 → DONE; else idx←idx+1 and load beat.
  - DONE: dump_done_o=1 for one cycle → IDLE.
- Beat load: dump_data_o←mem[next idx], with a same-cycle write to that index forwarded (wr_data_i) regardless of BYPASS. dump_addr_o←next idx. Index 0 always dumps 0.
- Beat stability: dump_addr_o and dump_data_o are registered and hold while dump_valid_o&&!dump_ready_i. Writes to an already-loaded index during a stall do not change the pending beat.
- dump_start_i is ignored outside IDLE, including in the DONE cycle.
- Normal reads and writes continue unaffected during a dump.

## Timing
- Reset values: mem all 0; FSM IDLE; idx 0; dump_busy_o, dump_valid_o, dump_done_o = 0; dump_addr_o = 0; dump_data_o = 0. rd_data_o is 0 for address 0 and 0 for every address after reset.
- Read latency 0 (combinational). Write visible to non-bypassed reads from the cycle after the write edge.
- Dump sampled at edge T: dump_valid_o and dump_busy_o high from T+1.
  - With dump_ready_i held high, DEPTH beats are accepted on consecutive edges T+1..T+DEPTH.
  - dump_done_o is high in cycle T+DEPTH+1; dump_busy_o falls at T+DEPTH+2.
  - Minimum start-to-start distance is DEPTH+2 cycles.
- dump_busy_o is high in SEND and DONE.
- Reset asserted mid-dump: immediate abort to IDLE with all outputs at reset values, no dump_done_o pulse, and the register contents cleared.

## Test plan
- Reset then read all addresses on every port → all 0. Write 0xDEADBEEF to x0, then read x0 → 0.
- Write 0x12345678 to x5 with rd_addr0=rd_addr1=5 in the same cycle: BYPASS=1 → both ports 0x12345678 that cycle; BYPASS=0 → 0 that cycle and 0x12345678 the next.
- Load x[i]=i*0x01010101, pulse dump_start_i with ready held high → 32 beats in 32 cycles, addr 0..31, data 0 then i*0x01010101; done pulse at T+33.
- Dump with ready toggled 1,0,0,1 and a write of 0xAAAA5555 to x3 while beat 3 is stalled → beat 3 holds its old value; a later read of x3 returns 0xAAAA5555.
- Assert rst_ni low at beat 10 of a dump → valid/busy drop asynchronously, no done pulse, all registers read 0. A new dump after release starts at addr 0.
- NRD=4, XLEN=64, DEPTH=16 build: random writes and four-port reads checked against a reference model; dump produces 16 beats.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with handshaked dump engine.
// Latency: reads combinational (0 cycles), writes visible next cycle; dump beat registered.
// Backpressure: dump beat holds (addr and data) while dump_valid_o && !dump_ready_i.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  dump_start_i,
    output logic                  dump_busy_o,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [AW-1:0]         dump_addr_o,
    output logic [XLEN-1:0]       dump_data_o,
    output logic                  dump_done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [XLEN-1:0] mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   beat_addr_q;
    logic [XLEN-1:0] beat_data_q;
    logic            load_beat;
    logic [AW-1:0]   load_idx;
    logic [XLEN-1:0] load_data;

    // Register storage; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Independent combinational read ports, x0 first, then optional write forwarding.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        assign ra   = rd_addr_i[k*AW +: AW];
        assign rdat = (ra == '0) ? '0 :
                      ((BYPASS != 0) && wr_en_i && (wr_addr_i == ra)) ? wr_data_i :
                      mem_q[ra];
        assign rd_data_o[k*XLEN +: XLEN] = rdat;
    end

    // Beat source: the dump always forwards a same-cycle write so the snapshot is current.
    assign load_data = (load_idx == '0) ? '0 :
                       (wr_en_i && (wr_addr_i == load_idx)) ? wr_data_i :
                       mem_q[load_idx];

    // Dump FSM next-state: walk every index once, then a single DONE cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_beat = 1'b0;
        load_idx  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start_i) begin
                    state_d   = S_SEND;
                    idx_d     = '0;
                    load_beat = 1'b1;
                    load_idx  = '0;
                end
            end
            S_SEND: begin
                if (dump_ready_i) begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        load_beat = 1'b1;
                        load_idx  = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Dump FSM state, index and the registered beat (held until accepted).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            beat_addr_q <= '0;
            beat_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_beat) begin
                beat_addr_q <= load_idx;
                beat_data_q <= load_data;
            end
        end
    end

    assign dump_busy_o  = (state_q != S_IDLE);
    assign dump_valid_o = (state_q == S_SEND);
    assign dump_done_o  = (state_q == S_DONE);
    assign dump_addr_o  = beat_addr_q;
    assign dump_data_o  = beat_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: default build (bypass on and off) plus a 64-bit, 16-deep, 4-port build.
// Latency: reads checked in the same cycle as driven, dump beats checked each cycle.
// Backpressure: dump_ready driven from fixed patterns and $urandom.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    // Default build inputs (shared by the bypass and non-bypass instances)
    logic [9:0]  ra_a;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        start_a;
    logic        ready_a;
    logic [63:0] rd_a, rd_b;
    logic        busy_a, valid_a, done_a, busy_b, valid_b, done_b;
    logic [4:0]  daddr_a, daddr_b;
    logic [31:0] ddata_a, ddata_b;

    // Wide build inputs
    logic [15:0]  ra_c;
    logic         we_c;
    logic [3:0]   wa_c;
    logic [63:0]  wd_c;
    logic         start_c;
    logic         ready_c;
    logic [255:0] rd_c;
    logic         busy_c, valid_c, done_c;
    logic [3:0]   daddr_c;
    logic [63:0]  ddata_c;

    regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .BYPASS(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(ra_a), .rd_data_o(rd_a),
        .wr_en_i(we_a), .wr_addr_i(wa_a), .wr_data_i(wd_a),
        .dump_start_i(start_a), .dump_busy_o(busy_a), .dump_valid_o(valid_a),
        .dump_ready_i(ready_a), .dump_addr_o(daddr_a), .dump_data_o(ddata_a),
        .dump_done_o(done_a));

    regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .BYPASS(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(ra_a), .rd_data_o(rd_b),
        .wr_en_i(we_a), .wr_addr_i(wa_a), .wr_data_i(wd_a),
        .dump_start_i(start_a), .dump_busy_o(busy_b), .dump_valid_o(valid_b),
        .dump_ready_i(ready_a), .dump_addr_o(daddr_b), .dump_data_o(ddata_b),
        .dump_done_o(done_b));

    regfile_mp #(.XLEN(64), .DEPTH(16), .NRD(4), .BYPASS(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(ra_c), .rd_data_o(rd_c),
        .wr_en_i(we_c), .wr_addr_i(wa_c), .wr_data_i(wd_c),
        .dump_start_i(start_c), .dump_busy_o(busy_c), .dump_valid_o(valid_c),
        .dump_ready_i(ready_c), .dump_addr_o(daddr_c), .dump_data_o(ddata_c),
        .dump_done_o(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference register contents
    logic [31:0] mem_a [32];
    logic [63:0] mem_c [16];
    logic [31:0] snap  [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] eb0;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) mem_a[i] = '0;
        for (int i = 0; i < 16; i++) mem_c[i] = '0;
    endtask

    // Spec-level read of the wide build: x0 is zero, then same-cycle write, then storage.
    function automatic logic [63:0] ref_rd_c(input logic [3:0] a);
        if (a == 4'd0) return 64'd0;
        if (we_c && (wa_c == a)) return wd_c;
        return mem_c[a];
    endfunction

    initial begin
        int acc;
        int cyc;
        bit wrote;
        bit seen;
        logic [3:0] rsel [4];
        bit rp [4];

        rst_n = 1'b0;
        ra_a = '0; we_a = 1'b0; wa_a = '0; wd_a = '0; start_a = 1'b0; ready_a = 1'b0;
        ra_c = '0; we_c = 1'b0; wa_c = '0; wd_c = '0; start_c = 1'b0; ready_c = 1'b0;
        clear_models();
        rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b0; rp[3] = 1'b1;

        tbl[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0,        32'h0};
        tbl[2] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h12345678};
        tbl[4] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd5,  32'hCAFEF00D, 32'h12345678, 32'h0};
        tbl[5] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd7,  32'h11111111, 32'h11111111, 32'hCAFEF00D};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h11111111, 32'h0,        32'h11111111};
        tbl[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h0};

        #12;
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_busy_a", {63'd0, busy_a}, 64'd0);
        chk("rst_valid_a", {63'd0, valid_a}, 64'd0);
        chk("rst_done_a", {63'd0, done_a}, 64'd0);
        chk("rst_daddr_a", {59'd0, daddr_a}, 64'd0);
        chk("rst_ddata_a", {32'd0, ddata_a}, 64'd0);
        chk("rst_busy_c", {63'd0, busy_c}, 64'd0);
        chk("rst_ddata_c", ddata_c, 64'd0);
        for (int a = 0; a < 32; a++) begin
            ra_a = {a[4:0], a[4:0]};
            #1;
            chk("rst_rd_a", rd_a, 64'd0);
            chk("rst_rd_b", rd_b, 64'd0);
        end
        for (int a = 0; a < 16; a++) begin
            ra_c = {4{a[3:0]}};
            #1;
            for (int j = 0; j < 4; j++) chk("rst_rd_c", rd_c[j*64 +: 64], 64'd0);
        end
        step();

        // Table-driven read/write/bypass vectors
        for (int i = 0; i < 8; i++) begin
            we_a = tbl[i].we; wa_a = tbl[i].wa; wd_a = tbl[i].wd;
            ra_a = {tbl[i].r1, tbl[i].r0};
            #1;
            chk($sformatf("tbl%0d_a0", i), {32'd0, rd_a[31:0]},  {32'd0, tbl[i].e0});
            chk($sformatf("tbl%0d_a1", i), {32'd0, rd_a[63:32]}, {32'd0, tbl[i].e1});
            chk($sformatf("tbl%0d_b0", i), {32'd0, rd_b[31:0]},  {32'd0, tbl[i].eb0});
            step();
            if (tbl[i].we && tbl[i].wa != 5'd0) mem_a[tbl[i].wa] = tbl[i].wd;
        end
        we_a = 1'b0;

        // Load x[i] = i*0x01010101
        for (int i = 1; i < 32; i++) begin
            we_a = 1'b1; wa_a = i[4:0]; wd_a = i * 32'h01010101;
            step();
            mem_a[i] = i * 32'h01010101;
        end
        we_a = 1'b0;

        // Dump with ready held high: beats on consecutive cycles, then done
        ready_a = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("d1_busy", {63'd0, busy_a}, 64'd1);
        for (int k = 0; k < 32; k++) begin
            chk("d1_valid", {63'd0, valid_a}, 64'd1);
            chk("d1_addr", {59'd0, daddr_a}, k);
            chk("d1_data_a", {32'd0, ddata_a}, {32'd0, mem_a[k]});
            chk("d1_data_b", {32'd0, ddata_b}, {32'd0, mem_a[k]});
            step();
        end
        chk("d1_done", {63'd0, done_a}, 64'd1);
        chk("d1_done_busy", {63'd0, busy_a}, 64'd1);
        chk("d1_done_valid", {63'd0, valid_a}, 64'd0);
        start_a = 1'b1;             // must be ignored in DONE
        step();
        start_a = 1'b0;
        chk("d1_idle_busy", {63'd0, busy_a}, 64'd0);
        chk("d1_idle_done", {63'd0, done_a}, 64'd0);
        step();
        chk("d1_start_ignored", {63'd0, busy_a}, 64'd0);

        // Dump with ready pattern 1,0,0,1 and a write to x3 while beat 3 stalls
        snap = mem_a;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        acc = 0; cyc = 0; wrote = 1'b0;
        while (acc < 32 && cyc < 200) begin
            ready_a = rp[cyc % 4];
            we_a = 1'b0;
            if (acc == 3 && !ready_a && !wrote) begin
                we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hAAAA5555; wrote = 1'b1;
            end
            #1;
            chk("d2_valid", {63'd0, valid_a}, 64'd1);
            chk("d2_addr", {59'd0, daddr_a}, acc);
            chk("d2_data", {32'd0, ddata_a}, {32'd0, snap[acc]});
            if (ready_a) acc++;
            step();
            if (we_a) mem_a[wa_a] = wd_a;
            cyc++;
        end
        we_a = 1'b0;
        chk("d2_all_beats", acc, 32);
        chk("d2_done", {63'd0, done_a}, 64'd1);
        ready_a = 1'b1;
        step();
        ra_a = {5'd3, 5'd3};
        #1;
        chk("d2_x3_a", {32'd0, rd_a[31:0]}, {32'd0, mem_a[3]});
        chk("d2_x3_b", {32'd0, rd_b[31:0]}, 64'hAAAA5555);

        // Reset asserted at beat 10
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("d3_at10", {59'd0, daddr_a}, 64'd10);
        rst_n = 1'b0;
        #1;
        chk("d3_valid", {63'd0, valid_a}, 64'd0);
        chk("d3_busy", {63'd0, busy_a}, 64'd0);
        chk("d3_done", {63'd0, done_a}, 64'd0);
        chk("d3_addr", {59'd0, daddr_a}, 64'd0);
        chk("d3_data", {32'd0, ddata_a}, 64'd0);
        clear_models();
        #3;
        rst_n = 1'b1;
        step();
        chk("d3_no_done", {63'd0, done_a}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            ra_a = {a[4:0], a[4:0]};
            #1;
            chk("d3_rd_zero", rd_a, 64'd0);
        end
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("d4_valid", {63'd0, valid_a}, 64'd1);
        chk("d4_addr0", {59'd0, daddr_a}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (done_a) seen = 1'b1;
            else step();
        end
        chk("d4_done_seen", {63'd0, seen}, 64'd1);
        step();

        // Wide build: random writes and four-port reads against the model
        for (int n = 0; n < 300; n++) begin
            we_c = 1'($urandom_range(0, 1));
            wa_c = 4'($urandom_range(0, 15));
            wd_c = {$urandom, $urandom};
            for (int j = 0; j < 4; j++) begin
                rsel[j] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) rsel[j] = wa_c;
            end
            ra_c = {rsel[3], rsel[2], rsel[1], rsel[0]};
            #1;
            for (int j = 0; j < 4; j++)
                chk($sformatf("rnd_c_p%0d", j), rd_c[j*64 +: 64], ref_rd_c(rsel[j]));
            step();
            if (we_c && wa_c != 4'd0) mem_c[wa_c] = wd_c;
        end
        we_c = 1'b0;

        // Wide build dump with random backpressure
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 16 && cyc < 400) begin
            ready_c = 1'($urandom_range(0, 1));
            #1;
            chk("dc_valid", {63'd0, valid_c}, 64'd1);
            if (ready_c) begin
                chk("dc_addr", {60'd0, daddr_c}, acc);
                chk("dc_data", ddata_c, mem_c[acc]);
                acc++;
            end
            step();
            cyc++;
        end
        chk("dc_all_beats", acc, 16);
        chk("dc_done", {63'd0, done_c}, 64'd1);
        step();
        chk("dc_idle", {63'd0, busy_c}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
